// File: rtl/bcd_fpu_pkg.sv
// Shared types and helpers for the decimal FPU add/sub path.
// Holds the normalizer state encoding and the BCD digit validity check.
package bcd_fpu_pkg;

  localparam int DIGIT_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } norm_state_t;

  function automatic logic is_bad_digit(input logic [DIGIT_W-1:0] d);
    return (d > 4'd9);
  endfunction

endpackage

// File: rtl/bcd_msd_check.sv
// Combinational flags for an N-digit BCD bus.
// Reports a nonzero most-significant digit and an all-zero bus.
module bcd_msd_check
  import bcd_fpu_pkg::*;
#(
  parameter int N = 25
) (
  input  logic [N*DIGIT_W-1:0] sig,
  output logic                 msd_nz,
  output logic                 sig_zero
);

  assign msd_nz   = |sig[N*DIGIT_W-1 -: DIGIT_W];
  assign sig_zero = ~|sig;

endmodule

// File: rtl/bcd_sub_normalize.sv
// Post-subtract stage: resolves the result sign and left-normalizes the
// BCD significand one digit per clock, decrementing the biased exponent.
module bcd_sub_normalize
  import bcd_fpu_pkg::*;
#(
  parameter int N  = 25,
  parameter int EW = 14,
  parameter int CW = $clog2(N)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_valid,
  output logic                 i_ready,
  input  logic [N*DIGIT_W-1:0] i_sig,
  input  logic                 i_co,
  input  logic                 i_sign,
  input  logic [EW-1:0]        i_exp,
  output logic                 o_valid,
  input  logic                 o_ready,
  output logic [N*DIGIT_W-1:0] o_sig,
  output logic [EW-1:0]        o_exp,
  output logic                 o_sign,
  output logic                 o_zero,
  output logic                 o_bad,
  output logic [CW-1:0]        o_shift
);

  norm_state_t         state_q, state_d;
  logic [N*DIGIT_W-1:0] sig_q, sig_d;
  logic [EW-1:0]        exp_q, exp_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 sign_q, sign_d;
  logic                 zero_q, zero_d;
  logic                 bad_q, bad_d;
  logic                 msd_nz;
  logic                 sig_zero;
  logic                 bad_any;

  bcd_msd_check #(.N(N)) u_msd_check (
    .sig      (sig_q),
    .msd_nz   (msd_nz),
    .sig_zero (sig_zero)
  );

  // Flag any non-decimal nibble on the incoming beat
  always_comb begin
    bad_any = 1'b0;
    for (int i = 0; i < N; i++) begin
      bad_any = bad_any | is_bad_digit(i_sig[i*DIGIT_W +: DIGIT_W]);
    end
  end

  // Next-state and working-register update
  always_comb begin
    state_d = state_q;
    sig_d   = sig_q;
    exp_d   = exp_q;
    cnt_d   = cnt_q;
    sign_d  = sign_q;
    zero_d  = zero_q;
    bad_d   = bad_q;
    case (state_q)
      IDLE: begin
        if (i_valid) begin
          sig_d   = i_sig;
          exp_d   = i_exp;
          sign_d  = i_sign ^ ~i_co;
          bad_d   = bad_any;
          zero_d  = 1'b0;
          cnt_d   = {CW{1'b0}};
          state_d = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        // Zero keeps the operand-derived sign; it is not forced positive
        if (sig_zero) begin
          zero_d  = 1'b1;
          state_d = DONE;
        end else if (msd_nz || (exp_q == {EW{1'b0}})) begin
          state_d = DONE;
        end else begin
          sig_d = {sig_q[N*DIGIT_W-DIGIT_W-1:0], {DIGIT_W{1'b0}}};
          exp_d = exp_q - {{(EW-1){1'b0}}, 1'b1};
          cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
        end
      end
      DONE: begin
        if (o_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and working registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sig_q   <= {(N*DIGIT_W){1'b0}};
      exp_q   <= {EW{1'b0}};
      cnt_q   <= {CW{1'b0}};
      sign_q  <= 1'b0;
      zero_q  <= 1'b0;
      bad_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sig_q   <= sig_d;
      exp_q   <= exp_d;
      cnt_q   <= cnt_d;
      sign_q  <= sign_d;
      zero_q  <= zero_d;
      bad_q   <= bad_d;
    end
  end

  assign i_ready = (state_q == IDLE);
  assign o_valid = (state_q == DONE);
  assign o_sig   = sig_q;
  assign o_exp   = exp_q;
  assign o_sign  = sign_q;
  assign o_zero  = zero_q;
  assign o_bad   = bad_q;
  assign o_shift = cnt_q;

endmodule

// File: tb/tb_bcd_sub_normalize.sv
// Directed self-checking bench for bcd_sub_normalize.
module tb_bcd_sub_normalize;

  localparam int N  = 25;
  localparam int EW = 14;
  localparam int CW = $clog2(N);
  localparam int W  = N * 4;

  logic          clk;
  logic          rst;
  logic          i_valid;
  logic          i_ready;
  logic [W-1:0]  i_sig;
  logic          i_co;
  logic          i_sign;
  logic [EW-1:0] i_exp;
  logic          o_valid;
  logic          o_ready;
  logic [W-1:0]  o_sig;
  logic [EW-1:0] o_exp;
  logic          o_sign;
  logic          o_zero;
  logic          o_bad;
  logic [CW-1:0] o_shift;

  int checks;
  int failures;
  int lat;
  logic [W-1:0] held_sig;

  bcd_sub_normalize #(.N(N), .EW(EW), .CW(CW)) dut (
    .clk     (clk),
    .rst     (rst),
    .i_valid (i_valid),
    .i_ready (i_ready),
    .i_sig   (i_sig),
    .i_co    (i_co),
    .i_sign  (i_sign),
    .i_exp   (i_exp),
    .o_valid (o_valid),
    .o_ready (o_ready),
    .o_sig   (o_sig),
    .o_exp   (o_exp),
    .o_sign  (o_sign),
    .o_zero  (o_zero),
    .o_bad   (o_bad),
    .o_shift (o_shift)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present one beat, accept it, then count edges until o_valid (bounded)
  task automatic send(input logic [W-1:0] sig, input logic [EW-1:0] e,
                      input logic co, input logic sg, output int edges);
    @(negedge clk);
    i_sig = sig; i_exp = e; i_co = co; i_sign = sg; i_valid = 1'b1;
    check("accept_ready", W'(i_ready), W'(1'b1));
    @(posedge clk); #1;
    i_valid = 1'b0;
    edges = 0;
    while (o_valid !== 1'b1 && edges < 200) begin
      @(posedge clk); #1;
      edges++;
    end
  endtask

  task automatic release_out();
    @(negedge clk);
    o_ready = 1'b1;
    @(posedge clk); #1;
    o_ready = 1'b0;
    check("release_valid", W'(o_valid), W'(1'b0));
    check("release_ready", W'(i_ready), W'(1'b1));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, W'(o_valid), W'(1'b0));
    check({tag, "_ready"}, W'(i_ready), W'(1'b1));
    check({tag, "_sig"},   o_sig,       {W{1'b0}});
    check({tag, "_exp"},   W'(o_exp),   W'(1'b0));
    check({tag, "_sign"},  W'(o_sign),  W'(1'b0));
    check({tag, "_zero"},  W'(o_zero),  W'(1'b0));
    check({tag, "_bad"},   W'(o_bad),   W'(1'b0));
    check({tag, "_shift"}, W'(o_shift), W'(1'b0));
  endtask

  initial begin
    checks = 0; failures = 0; lat = 0;
    rst = 1'b1; i_valid = 1'b0; i_sig = '0; i_co = 1'b0; i_sign = 1'b0;
    i_exp = '0; o_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("rst");
    @(negedge clk);
    rst = 1'b0;

    // 22 leading zero digits, then 123
    send({88'h0, 12'h123}, 14'd100, 1'b1, 1'b0, lat);
    check("basic_lat",   W'(lat),     W'(23));
    check("basic_sig",   o_sig,       {12'h123, 88'h0});
    check("basic_exp",   W'(o_exp),   W'(78));
    check("basic_shift", W'(o_shift), W'(22));
    check("basic_sign",  W'(o_sign),  W'(1'b0));
    check("basic_zero",  W'(o_zero),  W'(1'b0));
    release_out();

    // Exponent floor stops shifting with MSD still zero
    send({96'h0, 4'h1}, 14'd3, 1'b1, 1'b0, lat);
    check("floor_lat",   W'(lat),     W'(4));
    check("floor_sig",   o_sig,       {84'h0, 16'h1000});
    check("floor_exp",   W'(o_exp),   W'(0));
    check("floor_shift", W'(o_shift), W'(3));
    check("floor_zero",  W'(o_zero),  W'(1'b0));
    release_out();

    // Already normalized, negated result
    send({4'h5, 84'h0, 12'h789}, 14'd40, 1'b0, 1'b0, lat);
    check("norm_lat",   W'(lat),     W'(1));
    check("norm_sig",   o_sig,       {4'h5, 84'h0, 12'h789});
    check("norm_exp",   W'(o_exp),   W'(40));
    check("norm_sign",  W'(o_sign),  W'(1'b1));
    check("norm_shift", W'(o_shift), W'(0));
    check("norm_bad",   W'(o_bad),   W'(1'b0));
    release_out();

    // Zero result keeps sign of a
    send({W{1'b0}}, 14'd77, 1'b1, 1'b1, lat);
    check("zero_lat",   W'(lat),     W'(1));
    check("zero_zero",  W'(o_zero),  W'(1'b1));
    check("zero_exp",   W'(o_exp),   W'(77));
    check("zero_sign",  W'(o_sign),  W'(1'b1));
    check("zero_shift", W'(o_shift), W'(0));
    release_out();

    // Bad nibble plus backpressure; sign = 1 ^ ~0 = 0
    send({4'h9, 84'h0, 12'h0A0}, 14'd10, 1'b0, 1'b1, lat);
    check("bp_lat",  W'(lat),    W'(1));
    check("bp_bad",  W'(o_bad),  W'(1'b1));
    check("bp_sign", W'(o_sign), W'(1'b0));
    held_sig = {4'h9, 84'h0, 12'h0A0};
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("bp_hold_valid", W'(o_valid), W'(1'b1));
      check("bp_hold_ready", W'(i_ready), W'(1'b0));
      check("bp_hold_sig",   o_sig,       held_sig);
      check("bp_hold_exp",   W'(o_exp),   W'(10));
      check("bp_hold_bad",   W'(o_bad),   W'(1'b1));
    end
    release_out();

    // Reset during a 10-shift operation
    @(negedge clk);
    i_sig = {40'h0, 4'h7, 56'h0}; i_exp = 14'd50; i_co = 1'b1; i_sign = 1'b1;
    i_valid = 1'b1;
    @(posedge clk); #1;
    i_valid = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check_reset_outputs("midrst");
    @(negedge clk);
    rst = 1'b0;

    send({40'h0, 4'h7, 56'h0}, 14'd50, 1'b1, 1'b1, lat);
    check("after_lat",   W'(lat),     W'(11));
    check("after_sig",   o_sig,       {4'h7, 96'h0});
    check("after_exp",   W'(o_exp),   W'(40));
    check("after_shift", W'(o_shift), W'(10));
    check("after_sign",  W'(o_sign),  W'(1'b1));
    release_out();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
